ticker_alarm: RTL and testbench
===============================

Name: ticker_alarm

Overview:
- Bus-mapped compare/alarm unit that consumes the 32-bit 1 kHz millisecond tick count, already synchronised into the bus clock domain.
- Raises an interrupt when the count reaches a programmed compare value; supports one-shot and periodic auto-reload modes.
- Sits on the same peripheral bus as the tick source; its irq output goes to the CPU interrupt controller.

Parameters:
- DEFAULT_PERIOD, 32'd1000: reset value of the PERIOD register, in ticks.

Ports:
- clk_bus  input  1  bus clock; the only clock.
- rst  input  1  reset; asynchronous, active-high.
- tick_count  input  32  synchronised ms count; increments by 1 (wraps at 2^32) and is held for many clk_bus cycles.
- bus_address  input  8  byte address; bits [7:2] decoded, bits [1:0] ignored.
- bus_data_i  input  32  write data.
- bus_read  input  1  read strobe.
- bus_write  input  1  write strobe; one register write per asserted cycle.
- bus_data_o  output  32  read data.
- irq  output  1  interrupt, level.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Register map (word offsets):
  - 0x00 CTRL: [0] EN, [1] PERIODIC, [2] IEN; all other bits read 0.
  - 0x04 COMPARE: R/W.
  - 0x08 PERIOD: R/W.
  - 0x0C STATUS: [0] PEND, [1] OVR; write-1-to-clear.
  - 0x10 COUNT: read-only, returns tick_count.
  - Unmapped addresses read 0; writes to them are ignored.
- Read path: bus_data_o = bus_read ? selected register : 32'd0, combinational, zero latency.
- Reset values:
  - CTRL = 0, COMPARE = 0, PERIOD = DEFAULT_PERIOD, STATUS = 0.
  - tick_prev = 0, prev_valid = 0.
  - irq = 0; bus_data_o = 0 while bus_read is low.
- Edge detect:
  - Each cycle, tick_prev <= tick_count and prev_valid <= 1.
  - new_tick = prev_valid && (tick_count != tick_prev).
  - The first cycle after reset never produces new_tick.
- Match: match = EN && new_tick && (tick_count == COMPARE_current). Equality only, so wrap-around needs no special handling.
- On match, at the same clock edge:
  - PEND <= 1. If PEND was already 1, OVR <= 1.
  - If PERIODIC = 1 and PERIOD != 0: COMPARE <= COMPARE + PERIOD, modulo 2^32. EN stays 1.
  - Otherwise (one-shot, or PERIOD == 0): EN <= 0.
- States, implied by EN/PERIODIC:
  - DISABLED (EN = 0) -> ARMED on a CTRL write with EN = 1.
  - ARMED -> ARMED on match in periodic mode.
  - ARMED -> DISABLED on match in one-shot mode.
  - Any state -> DISABLED on a CTRL write with EN = 0.
- Arming is edge-based: enabling while tick_count already equals COMPARE does not fire until the count next reaches COMPARE, i.e. after 2^32 ticks.
- irq = PEND & IEN, driven from registers only (no combinational path from the bus). It updates in the cycle after the setting/clearing edge.
- Simultaneous events:
  - STATUS W1C in the same cycle as a match: set wins. PEND stays 1; OVR is set if PEND was 1 before the edge.
  - COMPARE write in the same cycle as a periodic match: the match uses the old COMPARE, and the bus write wins over the auto-reload.
  - CTRL write in the same cycle as a one-shot match: the bus write value of EN wins.
  - PERIOD write in the same cycle as a match: the reload uses the old PERIOD.
- Latency: tick_count changes to COMPARE before clock edge N -> PEND = 1 after edge N -> irq = 1 in cycle N+1 (if IEN = 1).
- Reset mid-operation: all state returns to reset values immediately. The first tick change after reset release is detected only after one cycle of prev_valid.

Test Plan:
1. Reset with tick_count = 5, then hold 5 for 10 cycles -> no match; irq = 0; STATUS reads 0; COUNT reads 5.
2. One-shot: COMPARE = 100, CTRL = 0x5, step tick_count 98 -> 99 -> 100 -> PEND = 1 and irq = 1 one cycle after the 100 edge; CTRL reads 0x4. Write STATUS = 0x1 -> irq drops the next cycle.
3. Periodic: COMPARE = 10, PERIOD = 5, CTRL = 0x7, run tick_count 9 -> 26 clearing PEND each time -> matches at 10, 15, 20, 25; COMPARE reads 30; OVR = 0.
4. Overrun and wrap: COMPARE = 0xFFFFFFFE, PERIOD = 3, periodic, no clearing; step to 0xFFFFFFFE, then wrap through to 1 -> second match at 0x00000001; OVR = 1; COMPARE reads 0x00000004.
5. Collision: STATUS W1C in the same cycle as a match edge with PEND = 0 -> PEND = 1 after the edge. COMPARE write of 50 on a periodic match edge -> COMPARE reads 50, not the reloaded value.
6. Enable-on-equal: tick_count = 7, COMPARE = 7, write CTRL = 0x5 -> no PEND; step to 8 -> still no PEND. Assert rst mid-run with PEND = 1 -> irq = 0 and all registers return to reset values immediately.

Source files
------------

// File: rtl/ticker_alarm.sv
`default_nettype none
// ============================================================================
// Module   : ticker_alarm
// Purpose  : Bus-mapped compare/alarm unit driven by the synchronised 1 kHz
//            millisecond tick count. Raises a level interrupt when the count
//            reaches COMPARE. It supports one-shot mode and periodic
//            auto-reload mode.
// Ports    : clk_bus      - bus clock (only clock)
//            rst          - asynchronous active-high reset
//            tick_count   - synchronised ms count, held many cycles per value
//            bus_address  - byte address, bits [7:2] decoded
//            bus_data_i   - write data
//            bus_read     - read strobe (read data is combinational)
//            bus_write    - write strobe, one register write per cycle
//            bus_data_o   - read data, zero when bus_read is low
//            irq          - level interrupt, PEND & IEN
// Registers: 0x00 CTRL    [0] EN, [1] PERIODIC, [2] IEN
//            0x04 COMPARE R/W
//            0x08 PERIOD  R/W
//            0x0C STATUS  [0] PEND, [1] OVR, write-1-to-clear
//            0x10 COUNT   read-only view of tick_count
// Revision : 1.0 - initial release
// ============================================================================
module ticker_alarm #(
    parameter logic [31:0] DEFAULT_PERIOD = 32'd1000
) (
    input  logic        clk_bus,
    input  logic        rst,
    input  logic [31:0] tick_count,
    input  logic [7:0]  bus_address,
    input  logic [31:0] bus_data_i,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic [31:0] bus_data_o,
    output logic        irq
);

    localparam logic [5:0] WORD_CTRL    = 6'h00;
    localparam logic [5:0] WORD_COMPARE = 6'h01;
    localparam logic [5:0] WORD_PERIOD  = 6'h02;
    localparam logic [5:0] WORD_STATUS  = 6'h03;
    localparam logic [5:0] WORD_COUNT   = 6'h04;

    logic        ctrl_en;
    logic        ctrl_periodic;
    logic        ctrl_ien;
    logic [31:0] compare;
    logic [31:0] period;
    logic        pend;
    logic        ovr;
    logic [31:0] tick_prev;
    logic        prev_valid;

    logic [5:0]  word;
    logic        wr_ctrl;
    logic        wr_compare;
    logic        wr_period;
    logic        wr_status;
    logic        new_tick;
    logic        match;
    logic        reload;
    logic        unused_addr_bits;

    // Byte lanes within a word are not decoded.
    assign unused_addr_bits = ^bus_address[1:0];
    assign word             = bus_address[7:2];

    assign wr_ctrl    = bus_write && (word == WORD_CTRL);
    assign wr_compare = bus_write && (word == WORD_COMPARE);
    assign wr_period  = bus_write && (word == WORD_PERIOD);
    assign wr_status  = bus_write && (word == WORD_STATUS);

    // A match needs an actual change of the count. Arming while the count
    // already equals COMPARE therefore waits for the next time the count
    // reaches COMPARE. The edge detector is only trusted after one cycle of
    // history following reset.
    assign new_tick = prev_valid && (tick_count != tick_prev);
    assign match    = ctrl_en && new_tick && (tick_count == compare);
    // A periodic unit with PERIOD == 0 behaves as one-shot.
    assign reload   = match && ctrl_periodic && (period != 32'd0);

    // Both operands are registers, so there is no path from the bus to irq.
    assign irq = pend & ctrl_ien;

    always_comb begin
        bus_data_o = 32'd0;
        if (bus_read) begin
            case (word)
                WORD_CTRL:    bus_data_o = {29'd0, ctrl_ien, ctrl_periodic, ctrl_en};
                WORD_COMPARE: bus_data_o = compare;
                WORD_PERIOD:  bus_data_o = period;
                WORD_STATUS:  bus_data_o = {30'd0, ovr, pend};
                WORD_COUNT:   bus_data_o = tick_count;
                default:      bus_data_o = 32'd0;
            endcase
        end
    end

    always_ff @(posedge clk_bus or posedge rst) begin
        if (rst) begin
            ctrl_en       <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_ien      <= 1'b0;
            compare       <= 32'd0;
            period        <= DEFAULT_PERIOD;
            pend          <= 1'b0;
            ovr           <= 1'b0;
            tick_prev     <= 32'd0;
            prev_valid    <= 1'b0;
        end else begin
            tick_prev  <= tick_count;
            prev_valid <= 1'b1;

            // A bus write to CTRL takes priority over the one-shot disarm.
            if (wr_ctrl) begin
                ctrl_en       <= bus_data_i[0];
                ctrl_periodic <= bus_data_i[1];
                ctrl_ien      <= bus_data_i[2];
            end else if (match && !reload) begin
                ctrl_en <= 1'b0;
            end

            // The match was evaluated against the old COMPARE. A bus write
            // then takes priority over the auto-reload.
            if (wr_compare) begin
                compare <= bus_data_i;
            end else if (reload) begin
                compare <= compare + period;
            end

            if (wr_period) begin
                period <= bus_data_i;
            end

            // A set takes priority over a simultaneous write-1-to-clear.
            if (match) begin
                pend <= 1'b1;
            end else if (wr_status && bus_data_i[0]) begin
                pend <= 1'b0;
            end

            if (match && pend) begin
                ovr <= 1'b1;
            end else if (wr_status && bus_data_i[1]) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ticker_alarm.sv
`default_nettype none
// ============================================================================
// Module   : tb_ticker_alarm
// Purpose  : Self-checking bench for ticker_alarm. It uses table-driven
//            vectors, hand-written corner-case sequences, and a randomized
//            phase checked against a register-level behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ticker_alarm;

    logic        clk_bus = 1'b0;
    logic        rst;
    logic [31:0] tick_count;
    logic [7:0]  bus_address;
    logic [31:0] bus_data_i;
    logic        bus_read;
    logic        bus_write;
    logic [31:0] bus_data_o;
    logic        irq;

    int tests = 0;
    int fails = 0;

    ticker_alarm #(.DEFAULT_PERIOD(32'd1000)) dut (
        .clk_bus     (clk_bus),
        .rst         (rst),
        .tick_count  (tick_count),
        .bus_address (bus_address),
        .bus_data_i  (bus_data_i),
        .bus_read    (bus_read),
        .bus_write   (bus_write),
        .bus_data_o  (bus_data_o),
        .irq         (irq)
    );

    always #5 clk_bus = ~clk_bus;

    // ------------------------------------------------------------------
    // Behavioural model: this is the programmer-visible register file.
    // ------------------------------------------------------------------
    bit          m_en, m_per, m_ien, m_pend, m_ovr, m_seen;
    logic [31:0] m_cmp, m_prd, m_last;

    task automatic m_reset();
        m_en = 0; m_per = 0; m_ien = 0; m_pend = 0; m_ovr = 0;
        m_cmp = 0; m_prd = 32'd1000; m_last = 0; m_seen = 0;
    endtask

    function automatic logic [31:0] m_read(input logic [7:0] a, input logic [31:0] t);
        int w = int'(a) / 4;
        if (w == 0) return {29'd0, m_ien, m_per, m_en};
        if (w == 1) return m_cmp;
        if (w == 2) return m_prd;
        if (w == 3) return {30'd0, m_ovr, m_pend};
        if (w == 4) return t;
        return 32'd0;
    endfunction

    task automatic m_step(input logic [31:0] t, input logic [7:0] a,
                          input logic [31:0] d, input bit wr);
        int  w     = int'(a) / 4;
        bit  fire  = m_en && m_seen && (t != m_last) && (t == m_cmp);
        bit  again = fire && m_per && (m_prd != 0);
        bit  was_p = m_pend;
        logic [31:0] old_prd = m_prd;
        if (fire) begin
            m_pend = 1;
            if (was_p) m_ovr = 1;
            if (again) m_cmp = m_cmp + old_prd;
            else       m_en  = 0;
        end
        if (wr) begin
            case (w)
                0: begin m_en = d[0]; m_per = d[1]; m_ien = d[2]; end
                1: m_cmp = d;
                2: m_prd = d;
                3: begin
                       if (d[0] && !fire) m_pend = 0;
                       if (d[1] && !(fire && was_p)) m_ovr = 0;
                   end
                default: ;
            endcase
        end
        m_last = t;
        m_seen = 1;
    endtask

    // ------------------------------------------------------------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    logic [31:0] samp_rd;
    logic        samp_irq;

    // One bus cycle. Inputs are driven at negedge. Read data is sampled
    // before the edge. irq is sampled 1 time unit after the edge.
    task automatic cyc(input logic [31:0] t, input logic [7:0] a,
                       input logic [31:0] d, input bit rd, input bit wr);
        @(negedge clk_bus);
        tick_count = t; bus_address = a; bus_data_i = d;
        bus_read = rd; bus_write = wr;
        #1;
        samp_rd = bus_data_o;
        check("rdata", samp_rd, rd ? m_read(a, t) : 32'd0);
        @(posedge clk_bus);
        m_step(t, a, d, wr);
        #1;
        samp_irq = irq;
        check("irq", {31'd0, samp_irq}, {31'd0, m_pend & m_ien});
    endtask

    task automatic wr_reg(input logic [31:0] t, input logic [7:0] a, input logic [31:0] d);
        cyc(t, a, d, 1'b0, 1'b1);
    endtask

    task automatic rd_reg(input string name, input logic [31:0] t,
                          input logic [7:0] a, input logic [31:0] exp);
        cyc(t, a, 32'd0, 1'b1, 1'b0);
        check(name, samp_rd, exp);
    endtask

    typedef struct {
        logic [31:0] tick;
        logic [7:0]  addr;
        logic [31:0] data;
        bit          rd;
        bit          wr;
        logic [31:0] exp_rd;
        bit          exp_irq;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [31:0] t;
        int          hits;
        logic [31:0] hit_tick [4];

        rst = 1; tick_count = 32'd5; bus_address = 0; bus_data_i = 0;
        bus_read = 0; bus_write = 0;
        m_reset();
        repeat (3) @(posedge clk_bus);
        @(negedge clk_bus);
        rst = 0;

        // Test 1: idle after reset, then test 2: one-shot.
        for (int i = 0; i < 8; i++)
            tbl.push_back('{32'd5, 8'h0C, 32'd0, 1'b1, 1'b0, 32'd0, 1'b0});
        tbl.push_back('{32'd5,   8'h10, 32'd0,   1'b1, 1'b0, 32'd5, 1'b0});
        tbl.push_back('{32'd5,   8'h00, 32'd0,   1'b1, 1'b0, 32'd0, 1'b0});
        tbl.push_back('{32'd98,  8'h04, 32'd100, 1'b0, 1'b1, 32'd0, 1'b0});
        tbl.push_back('{32'd98,  8'h00, 32'd5,   1'b0, 1'b1, 32'd0, 1'b0});
        tbl.push_back('{32'd99,  8'h0C, 32'd0,   1'b1, 1'b0, 32'd0, 1'b0});
        tbl.push_back('{32'd100, 8'h0C, 32'd0,   1'b1, 1'b0, 32'd0, 1'b1});
        tbl.push_back('{32'd100, 8'h00, 32'd0,   1'b1, 1'b0, 32'd4, 1'b1});
        tbl.push_back('{32'd100, 8'h0C, 32'd0,   1'b1, 1'b0, 32'd1, 1'b1});
        tbl.push_back('{32'd100, 8'h0C, 32'd1,   1'b0, 1'b1, 32'd0, 1'b0});
        tbl.push_back('{32'd100, 8'h0F, 32'd0,   1'b1, 1'b0, 32'd0, 1'b0});

        foreach (tbl[i]) begin
            cyc(tbl[i].tick, tbl[i].addr, tbl[i].data, tbl[i].rd, tbl[i].wr);
            if (tbl[i].rd) check($sformatf("vec%0d_rd", i), samp_rd, tbl[i].exp_rd);
            check($sformatf("vec%0d_irq", i), {31'd0, samp_irq}, {31'd0, tbl[i].exp_irq});
        end

        // Test 3: periodic mode, PEND cleared after each match.
        wr_reg(32'd9, 8'h04, 32'd10);
        wr_reg(32'd9, 8'h08, 32'd5);
        wr_reg(32'd9, 8'h00, 32'd7);
        hits = 0;
        for (int k = 10; k <= 26; k++) begin
            cyc(k, 8'h00, 32'd0, 1'b0, 1'b0);
            if (samp_irq) begin
                if (hits < 4) hit_tick[hits] = k;
                hits++;
                wr_reg(k, 8'h0C, 32'd1);
            end
        end
        check("per_hits", hits, 32'd4);
        for (int i = 0; i < 4 && i < hits; i++)
            check($sformatf("per_hit%0d", i), hit_tick[i], 32'd10 + 32'(5 * i));
        rd_reg("per_compare", 32'd26, 8'h04, 32'd30);
        rd_reg("per_status", 32'd26, 8'h0C, 32'd0);

        // Test 4: overrun across the 2^32 wrap.
        wr_reg(32'd26, 8'h00, 32'd0);
        wr_reg(32'hFFFF_FFFD, 8'h04, 32'hFFFF_FFFE);
        wr_reg(32'hFFFF_FFFD, 8'h08, 32'd3);
        wr_reg(32'hFFFF_FFFD, 8'h00, 32'd7);
        cyc(32'hFFFF_FFFE, 8'h00, 32'd0, 1'b0, 1'b0);
        check("wrap_irq1", {31'd0, samp_irq}, 32'd1);
        rd_reg("wrap_cmp1", 32'hFFFF_FFFF, 8'h04, 32'd1);
        cyc(32'd0, 8'h00, 32'd0, 1'b0, 1'b0);
        cyc(32'd1, 8'h00, 32'd0, 1'b0, 1'b0);
        rd_reg("wrap_status", 32'd1, 8'h0C, 32'd3);
        rd_reg("wrap_compare", 32'd1, 8'h04, 32'd4);

        // Test 5: bus/match collisions.
        wr_reg(32'd200, 8'h00, 32'd0);
        wr_reg(32'd200, 8'h0C, 32'd3);
        wr_reg(32'd200, 8'h04, 32'd201);
        wr_reg(32'd200, 8'h08, 32'd10);
        wr_reg(32'd200, 8'h00, 32'd7);
        wr_reg(32'd201, 8'h0C, 32'd1);
        rd_reg("coll_w1c", 32'd201, 8'h0C, 32'd1);
        rd_reg("coll_cmp_reload", 32'd201, 8'h04, 32'd211);
        wr_reg(32'd201, 8'h0C, 32'd1);
        wr_reg(32'd211, 8'h04, 32'd50);
        rd_reg("coll_cmp_wr", 32'd211, 8'h04, 32'd50);
        rd_reg("coll_status", 32'd211, 8'h0C, 32'd1);

        // Test 6: enable while equal, then asynchronous reset with PEND set.
        wr_reg(32'd7, 8'h00, 32'd0);
        wr_reg(32'd7, 8'h0C, 32'd3);
        wr_reg(32'd7, 8'h04, 32'd7);
        wr_reg(32'd7, 8'h00, 32'd5);
        rd_reg("eq_arm", 32'd7, 8'h0C, 32'd0);
        cyc(32'd8, 8'h00, 32'd0, 1'b0, 1'b0);
        rd_reg("eq_step", 32'd8, 8'h0C, 32'd0);
        wr_reg(32'd8, 8'h04, 32'd9);
        wr_reg(32'd8, 8'h00, 32'd5);
        cyc(32'd9, 8'h00, 32'd0, 1'b0, 1'b0);
        check("pre_rst_irq", {31'd0, samp_irq}, 32'd1);
        @(negedge clk_bus);
        bus_write = 0; bus_read = 1; bus_address = 8'h00;
        #2 rst = 1;
        m_reset();
        #1 check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_ctrl", bus_data_o, 32'd0);
        bus_address = 8'h04; #1 check("rst_compare", bus_data_o, 32'd0);
        bus_address = 8'h08; #1 check("rst_period", bus_data_o, 32'd1000);
        bus_address = 8'h0C; #1 check("rst_status", bus_data_o, 32'd0);
        bus_read = 0;        #1 check("rst_rd_low", bus_data_o, 32'd0);
        @(negedge clk_bus);
        rst = 0;

        // Randomized phase against the model, starting near the wrap.
        t = 32'hFFFF_FFF0;
        for (int n = 0; n < 3000; n++) begin
            int          op   = int'($urandom_range(0, 9));
            bit          rd   = 1'($urandom_range(0, 1));
            logic [7:0]  a;
            logic [31:0] d    = $urandom;
            bit          wr   = 1;
            if ($urandom_range(0, 2) == 0) t = t + 1;
            case (op)
                0: begin a = 8'h00; if ($urandom_range(0, 3) != 0) d[0] = 1; end
                1: begin a = 8'h04; d = t + $urandom_range(0, 5); end
                2: begin a = 8'h08; d = $urandom_range(0, 4); end
                3: a = 8'h0C;
                4: a = 8'(($urandom_range(5, 63) << 2) | $urandom_range(0, 3));
                default: begin
                    wr = 0;
                    a  = 8'(($urandom_range(0, 7) << 2) | $urandom_range(0, 3));
                end
            endcase
            cyc(t, a, d, rd, wr);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
